// File: rtl/series_pkg.sv
// Shared types and arithmetic helpers for the power-series evaluator.
package series_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL1,
    S_MUL2,
    S_ACC,
    S_DONE
  } state_e;

  localparam int unsigned DEF_FRAC = 12;
  localparam int unsigned ONE      = 1 << DEF_FRAC;

  // round(2^frac / k); k = 0 has no meaningful coefficient and yields 0.
  function automatic int unsigned coef_val(input int unsigned frac, input int unsigned k);
    if (k == 0) return 0;
    return ((32'd1 << frac) + k / 2) / k;
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                 input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/series_coef_rom.sv
// Combinational k -> round(2^FRAC / k) lookup used for the 1/k factor of each term.
module series_coef_rom
  import series_pkg::*;
#(
  parameter int W         = 16,
  parameter int FRAC      = 12,
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic [CNT_W-1:0] k_i,
  output logic [W-1:0]     coef_o
);

  always_comb begin
    coef_o = '0;
    for (int i = 1; i <= MAX_TERMS; i++) begin
      if (k_i == CNT_W'(i)) coef_o = W'(coef_val(FRAC, i));
    end
  end

endmodule

// File: rtl/series_engine.sv
// Fixed-point e^x / e^-x series evaluator: one shared multiplier builds each
// term from the previous one (t *= x, then t *= 1/k) while a saturating adder sums.
module series_engine
  import series_pkg::*;
#(
  parameter int W         = 16,
  parameter int FRAC      = 12,
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic signed [W-1:0] x,
  input  logic [CNT_W-1:0]    n_terms,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] result,
  output logic                ovf
);

  localparam logic signed [W-1:0] ONE_T = W'(longint'(1) << FRAC);

  state_e              state_q, state_d;
  logic signed [W-1:0] t_q, t_d, r_q, r_d, x_q, x_d;
  logic [CNT_W-1:0]    k_q, k_d, n_q, n_d;
  logic                neg_q, neg_d, ovf_q, ovf_d, mode_q, mode_d;

  logic signed [W-1:0]     coef, mul_b;
  logic signed [2*W-1:0]   prod, prod_sh;
  logic signed [W:0]       acc_sum;
  logic signed [63:0]      mul_sat, acc_sat;
  logic                    mul_hit, acc_hit;
  logic [CNT_W-1:0]        n_clamped;

  series_coef_rom #(
    .W(W), .FRAC(FRAC), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)
  ) u_coef (
    .k_i   (k_q),
    .coef_o(coef)
  );

  // MUL1 scales by x, MUL2 by 1/k; k has already advanced past the ACC that preceded them.
  assign mul_b   = (state_q == S_MUL1) ? x_q : coef;
  assign prod    = $signed((2*W)'(t_q)) * $signed((2*W)'(mul_b));
  assign prod_sh = prod >>> FRAC;
  assign mul_sat = sat_val(64'(prod_sh), W);
  assign mul_hit = sat_hit(64'(prod_sh), W);

  assign acc_sum = neg_q ? ((W+1)'(r_q) - (W+1)'(t_q)) : ((W+1)'(r_q) + (W+1)'(t_q));
  assign acc_sat = sat_val(64'(acc_sum), W);
  assign acc_hit = sat_hit(64'(acc_sum), W);

  assign n_clamped = (n_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : n_terms;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    r_d     = r_q;
    k_d     = k_q;
    n_d     = n_q;
    x_d     = x_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          mode_d  = mode;
          n_d     = n_clamped;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        t_d     = ONE_T;
        r_d     = '0;
        k_d     = '0;
        neg_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = (n_q == '0) ? S_DONE : S_ACC;
      end
      S_ACC: begin
        r_d     = W'(acc_sat);
        ovf_d   = ovf_q | acc_hit;
        k_d     = k_q + 1'b1;
        neg_d   = neg_q ^ mode_q;
        state_d = (k_q + 1'b1 == n_q) ? S_DONE : S_MUL1;
      end
      S_MUL1: begin
        t_d     = W'(mul_sat);
        ovf_d   = ovf_q | mul_hit;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        t_d     = W'(mul_sat);
        ovf_d   = ovf_q | mul_hit;
        state_d = S_ACC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      x_q     <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      r_q     <= r_d;
      k_q     <= k_d;
      n_q     <= n_d;
      x_q     <= x_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_INIT) || (state_q == S_MUL1) ||
                  (state_q == S_MUL2) || (state_q == S_ACC);
  assign done   = (state_q == S_DONE);
  assign result = r_q;
  assign ovf    = ovf_q;

endmodule
